// File: rtl/typedefs.sv
// Shared types for the lab CPU: opcodes, sequencer phases, strobe bundle.
package typedefs;

    typedef enum logic [2:0] {
        HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE,
        OP_ADDR, OP_FETCH, ALU_OP, STORE
    } state_t;

    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic load_ir;
        logic load_ac;
        logic inc_pc;
        logic load_pc;
        logic halt;
    } strobe_t;

    function automatic logic is_aluop(opcode_t op);
        return op inside {ADD, AND, XOR, LDA};
    endfunction

endpackage

// File: rtl/cpu_ctl_if.sv
// Controller <-> datapath bundle: opcode/zero in, strobes and debug out.
// instr_cnt exists only when CPU_CTL_INSTR_CNT_EN is defined.
interface cpu_ctl_if #(parameter int CNT_W = 16);
    import typedefs::*;

    opcode_t opcode;
    logic    zero;
    logic    mem_rd;
    logic    mem_wr;
    logic    load_ir;
    logic    load_ac;
    logic    inc_pc;
    logic    load_pc;
    logic    halt;
    state_t  phase;
`ifdef CPU_CTL_INSTR_CNT_EN
    logic [CNT_W-1:0] instr_cnt;
`endif

    modport master (
        input  opcode, zero,
        output mem_rd, mem_wr, load_ir, load_ac,
        output inc_pc, load_pc, halt, phase
`ifdef CPU_CTL_INSTR_CNT_EN
        , output instr_cnt
`endif
    );

    modport slave (
        output opcode, zero,
        input  mem_rd, mem_wr, load_ir, load_ac,
        input  inc_pc, load_pc, halt, phase
`ifdef CPU_CTL_INSTR_CNT_EN
        , input instr_cnt
`endif
    );

endinterface

// File: rtl/cpu_ctl_dec.sv
// Combinational strobe decode from (phase, opcode, zero).
module cpu_ctl_dec
    import typedefs::*;
(
    input  state_t  phase,
    input  opcode_t opcode,
    input  logic    zero,
    output strobe_t strb
);

    logic aluop;

    assign aluop = is_aluop(opcode);

    always_comb begin
        strb = '0;
        unique case (1'b1)
            phase == INST_FETCH: begin
                strb.mem_rd = 1'b1;
            end
            phase == INST_LOAD,
            phase == IDLE: begin
                strb.mem_rd  = 1'b1;
                strb.load_ir = 1'b1;
            end
            phase == OP_ADDR: begin
                strb.inc_pc = (opcode != HLT);
                strb.halt   = (opcode == HLT);
            end
            phase == OP_FETCH: begin
                strb.mem_rd = aluop;
            end
            phase == ALU_OP: begin
                strb.load_ac = aluop;
                strb.mem_rd  = aluop;
                strb.inc_pc  = (opcode == SKZ) && zero;
                strb.load_pc = (opcode == JMP);
            end
            phase == STORE: begin
                strb.load_ac = aluop;
                strb.mem_rd  = aluop;
                strb.inc_pc  = (opcode == JMP);
                strb.load_pc = (opcode == JMP);
                strb.mem_wr  = (opcode == STO);
            end
            default: begin
                strb = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_ctl.sv
// Eight-phase fetch/execute sequencer with sticky halt.
// Optional retired-instruction counter under CPU_CTL_INSTR_CNT_EN.
module cpu_ctl
    import typedefs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst_,
    cpu_ctl_if.master bus
);

    state_t  phase_q;
    logic    halted;
    strobe_t dec;

    cpu_ctl_dec u_dec (
        .phase  (phase_q),
        .opcode (bus.opcode),
        .zero   (bus.zero),
        .strb   (dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_) begin
            phase_q <= INST_ADDR;
            halted  <= 1'b0;
        end else if (!halted) begin
            if (phase_q == OP_ADDR && bus.opcode == HLT) begin
                halted  <= 1'b1;
                phase_q <= INST_ADDR;
            end else begin
                // STORE wraps back to INST_ADDR
                phase_q <= state_t'(phase_q + 3'd1);
            end
        end
    end

    assign bus.mem_rd  = dec.mem_rd  & ~halted;
    assign bus.mem_wr  = dec.mem_wr  & ~halted;
    assign bus.load_ir = dec.load_ir & ~halted;
    assign bus.load_ac = dec.load_ac & ~halted;
    assign bus.inc_pc  = dec.inc_pc  & ~halted;
    assign bus.load_pc = dec.load_pc & ~halted;
    assign bus.halt    = dec.halt    |  halted;
    assign bus.phase   = phase_q;

`ifdef CPU_CTL_INSTR_CNT_EN
    logic [CNT_W-1:0] cnt;

    // HLT never reaches STORE, so it is never counted
    always_ff @(posedge clk) begin
        if (!rst_) begin
            cnt <= '0;
        end else if (!halted && phase_q == STORE && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.instr_cnt = cnt;
`endif

endmodule

// File: tb/tb_cpu_ctl.sv
// Bench for cpu_ctl: per-cycle reference model plus directed literal checks.
module tb_cpu_ctl;
    import typedefs::*;

    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_;
    int   total = 0;
    int   passed = 0;

    cpu_ctl_if #(.CNT_W(CW)) bus ();

    cpu_ctl #(.CNT_W(CW)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: step index within the instruction, halt flag, count
    int  mk = 0;
    bit  mh = 0;
    int  mc = 0;
    bit  armed = 0;

    function automatic logic [6:0] model_strb(int k, opcode_t op,
                                              logic z, bit h);
        bit alu;
        logic rd, wr, ir, ac, inc, pc, hl;
        alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        if (h) return 7'b0000001;
        rd  = (k >= 1 && k <= 3) || (k >= 5 && alu);
        wr  = (k == 7) && (op == STO);
        ir  = (k == 2) || (k == 3);
        ac  = (k >= 6) && alu;
        inc = (k == 4 && op != HLT) || (k == 6 && op == SKZ && z)
              || (k == 7 && op == JMP);
        pc  = (k >= 6) && (op == JMP);
        hl  = (k == 4) && (op == HLT);
        return {rd, wr, ir, ac, inc, pc, hl};
    endfunction

    function automatic logic [6:0] dut_strb();
        return {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_ac,
                bus.inc_pc, bus.load_pc, bus.halt};
    endfunction

    always @(posedge clk) begin
        if (!rst_) begin
            mk = 0; mh = 0; mc = 0; armed = 1;
        end else if (!mh) begin
            if (mk == 4 && bus.opcode == HLT) begin
                mh = 1; mk = 0;
            end else begin
                if (mk == 7 && mc < MAXC) mc++;
                mk = (mk + 1) % 8;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_phase", 32'(int'(bus.phase)), 32'(mk));
            check("model_strobes", 32'(dut_strb()),
                  32'(model_strb(mk, bus.opcode, bus.zero, mh)));
`ifdef CPU_CTL_INSTR_CNT_EN
            check("model_cnt", 32'(bus.instr_cnt), 32'(mc));
`endif
        end
    end

    logic [7:0] tr_rd, tr_wr, tr_ac, tr_inc, tr_pc, tr_hl;

    // Caller sits 1 time unit after a rising edge
    task automatic run_instr(input opcode_t op, input logic z);
        bus.opcode = op;
        bus.zero   = z;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tr_rd[k]  = bus.mem_rd;
            tr_wr[k]  = bus.mem_wr;
            tr_ac[k]  = bus.load_ac;
            tr_inc[k] = bus.inc_pc;
            tr_pc[k]  = bus.load_pc;
            tr_hl[k]  = bus.halt;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int bad;
        rst_ = 1'b0;
        bus.opcode = LDA;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;
        #2;
        check("rst_phase", 32'(int'(bus.phase)), 32'(int'(INST_ADDR)));
        check("rst_strobes", 32'(dut_strb()), 32'h0);

        run_instr(LDA, 1'b0);
        check("lda_mem_rd", 32'(tr_rd), 32'hEE);
        check("lda_load_ac", 32'(tr_ac), 32'hC0);
        check("lda_inc_pc", 32'(tr_inc), 32'h10);

        run_instr(SKZ, 1'b1);
        check("skz_z1_inc_pc", 32'(tr_inc), 32'h50);
        run_instr(SKZ, 1'b0);
        check("skz_z0_inc_pc", 32'(tr_inc), 32'h10);

        run_instr(JMP, 1'b0);
        check("jmp_load_pc", 32'(tr_pc), 32'hC0);
        check("jmp_inc_pc", 32'(tr_inc), 32'h90);
        check("jmp_mem_rd", 32'(tr_rd), 32'h0E);

        run_instr(STO, 1'b0);
        check("sto_mem_wr", 32'(tr_wr), 32'h80);
        check("sto_load_ac", 32'(tr_ac), 32'h00);

        run_instr(HLT, 1'b0);
        check("hlt_halt", 32'(tr_hl), 32'hF0);
        check("hlt_inc_pc", 32'(tr_inc), 32'h00);

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.phase != INST_ADDR || dut_strb() != 7'b0000001)
                bad++;
            @(posedge clk); #1;
        end
        check("halt_freeze", 32'(bad), 32'h0);

        rst_ = 1'b0;
        @(posedge clk); #1;
        rst_ = 1'b1;
        #2;
        check("unhalt_halt", 32'(bus.halt), 32'h0);
        check("unhalt_phase", 32'(int'(bus.phase)), 32'(int'(INST_ADDR)));

        run_instr(LDA, 1'b0);
        check("restart_mem_rd", 32'(tr_rd), 32'hEE);

        bus.opcode = ADD;
        repeat (6) @(posedge clk);
        #1;
        check("add_at_alu", 32'(int'(bus.phase)), 32'(int'(ALU_OP)));
        check("add_alu_ac", 32'(bus.load_ac), 32'h1);
        rst_ = 1'b0;
        @(posedge clk); #1;
        rst_ = 1'b1;
        #2;
        check("abort_phase", 32'(int'(bus.phase)), 32'(int'(INST_ADDR)));
        check("abort_ac", 32'(bus.load_ac), 32'h0);
`ifdef CPU_CTL_INSTR_CNT_EN
        check("cnt_after_rst", 32'(bus.instr_cnt), 32'h0);
`endif

        repeat (3) run_instr(ADD, 1'b0);
`ifdef CPU_CTL_INSTR_CNT_EN
        check("cnt_three", 32'(bus.instr_cnt), 32'h3);
`endif
        run_instr(ADD, 1'b0);
`ifdef CPU_CTL_INSTR_CNT_EN
        check("cnt_saturate", 32'(bus.instr_cnt), 32'h3);
`endif
        check("add_load_ac", 32'(tr_ac), 32'hC0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
